// File: rtl/decode_ctrl_pkg.sv
// Shared decode definitions: opcode constants, immediate-format encodings,
// buffer state encoding and the buffered entry layout.
// No logic; helper functions classify an opcode into format / illegal.
package decode_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int INSTR_SIZE = 32;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } immsel_e;

    // Occupancy-encoded buffer state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [INSTR_SIZE-1:0] instr;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       imm;
        immsel_e               immsel;
        logic                  illegal;
    } entry_t;

    function automatic immsel_e opc_immsel(input logic [6:0] opc);
        immsel_e sel;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: sel = IMM_I;
            OPC_STORE:                      sel = IMM_S;
            OPC_BRANCH:                     sel = IMM_B;
            OPC_LUI, OPC_AUIPC:             sel = IMM_U;
            OPC_JAL:                        sel = IMM_J;
            default:                        sel = IMM_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic opc_illegal(input logic [6:0] opc);
        logic ill;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP: ill = 1'b0;
            default:                              ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/decode_ctrl_immgen.sv
// Immediate generator: sign-extended immediate for the instruction's format.
// Latency: combinational, 0 cycles. Backpressure: none (pure function).
// Ports: instr_i (instruction word) -> imm_o (immediate, 0 for no-format/unknown).
module decode_ctrl_immgen
    import decode_ctrl_pkg::*;
(
    input  logic [INSTR_SIZE-1:0] instr_i,
    output logic [XLEN-1:0]       imm_o
);

    always_comb begin
        imm_o = '0;
        case (opc_immsel(instr_i[6:0]))
            IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode-stage controller: fetch -> 2-entry skid buffer -> execute, with immediate decode.
// Latency: 1 cycle accept-to-output when empty or popping; 1 instr/cycle sustained.
// Backpressure: if_ready drops only when both entries are full; flush empties the buffer.
// Ports: clk/rstn; flush; fetch side if_valid/if_ready/if_instr/if_pc;
//        execute side id_valid/id_ready/id_instr/id_pc/id_imm/id_immsel/id_illegal;
//        dec_count counts entries handed to execute (wraps).
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [INSTR_SIZE-1:0] if_instr,
    input  logic [XLEN-1:0]       if_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [INSTR_SIZE-1:0] id_instr,
    output logic [XLEN-1:0]       id_pc,
    output logic [XLEN-1:0]       id_imm,
    output logic [2:0]            id_immsel,
    output logic                  id_illegal,
    output logic [CNT_W-1:0]      dec_count
);

    state_e            state_q;
    entry_t            head_q;
    entry_t            tail_q;
    entry_t            entry_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   imm_d;
    logic              acc;
    logic              pop;

    decode_ctrl_immgen u_immgen (
        .instr_i (if_instr),
        .imm_o   (imm_d)
    );

    always_comb begin
        entry_d         = '0;
        entry_d.instr   = if_instr;
        entry_d.pc      = if_pc;
        entry_d.imm     = imm_d;
        entry_d.immsel  = opc_immsel(if_instr[6:0]);
        entry_d.illegal = opc_illegal(if_instr[6:0]);
    end

    // Both handshake qualifiers are decoded straight from state_q, so neither
    // ready nor valid has a combinational path from the opposite side.
    assign if_ready = (state_q != ST_TWO);
    assign id_valid = (state_q != ST_EMPTY);
    assign acc      = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // A pop coinciding with flush still completes and is counted.
            if (pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (flush) begin
                state_q <= ST_EMPTY;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (acc) begin
                            head_q  <= entry_d;
                            state_q <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (acc && pop) begin
                            head_q <= entry_d;
                        end else if (acc) begin
                            tail_q  <= entry_d;
                            state_q <= ST_TWO;
                        end else if (pop) begin
                            state_q <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // No accept possible here: if_ready is low.
                        if (pop) begin
                            head_q  <= tail_q;
                            state_q <= ST_ONE;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign id_instr   = head_q.instr;
    assign id_pc      = head_q.pc;
    assign id_imm     = head_q.imm;
    assign id_immsel  = head_q.immsel;
    assign id_illegal = head_q.illegal;
    assign dec_count  = cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
module tb_decode_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_imm;
    logic [2:0]  id_immsel;
    logic        id_illegal;
    logic [31:0] dec_count;

    // Narrow-counter instance sharing the same stimulus, used to observe wrap.
    logic        d2_if_ready;
    logic        d2_id_valid;
    logic [31:0] d2_id_instr;
    logic [31:0] d2_id_pc;
    logic [31:0] d2_id_imm;
    logic [2:0]  d2_id_immsel;
    logic        d2_id_illegal;
    logic [1:0]  d2_dec_count;

    always #5 clk = ~clk;

    decode_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_imm(id_imm), .id_immsel(id_immsel), .id_illegal(id_illegal),
        .dec_count(dec_count)
    );

    decode_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .if_valid(if_valid), .if_ready(d2_if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .id_valid(d2_id_valid), .id_ready(id_ready), .id_instr(d2_id_instr), .id_pc(d2_id_pc),
        .id_imm(d2_id_imm), .id_immsel(d2_id_immsel), .id_illegal(d2_id_illegal),
        .dec_count(d2_dec_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  sel;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an instruction with the values the bench expects it to decode to.
    task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [2:0] sel, input logic ill);
        if_valid  = 1'b1;
        if_instr  = ins;
        if_pc     = pc;
        cur.instr = ins;
        cur.pc    = pc;
        cur.imm   = imm;
        cur.sel   = sel;
        cur.ill   = ill;
    endtask

    // One clock: observe handshakes at the falling edge, update the scoreboard,
    // then return just after the rising edge so the caller can drive inputs.
    task automatic cyc();
        exp_t h;
        @(negedge clk);
        if (id_valid && id_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL pop_unexpected: observed=pop with empty scoreboard instr=%0h expected=no pop", id_instr);
            end
            if (sb.size() != 0) begin
                h = sb.pop_front();
                check("id_instr", id_instr, h.instr);
                check("id_pc", id_pc, h.pc);
                check("id_imm", id_imm, h.imm);
                check("id_immsel", id_immsel, h.sel);
                check("id_illegal", id_illegal, h.ill);
            end
            exp_cnt++;
        end
        if (flush) sb.delete();
        if (if_valid && if_ready && !flush) sb.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = '0;
        if_pc    = '0;
        id_ready = 1'b0;
        #1;
        check("rst_if_ready", if_ready, 1);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_instr", id_instr, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_imm", id_imm, 0);
        check("rst_id_immsel", id_immsel, 0);
        check("rst_id_illegal", id_illegal, 0);
        check("rst_dec_count", dec_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Single accept, one-cycle latency, then pop.
        put(32'hFFF00093, 32'h0, 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc();
        if_valid = 1'b0;
        check("lat_id_valid", id_valid, 1);
        check("lat_id_imm", id_imm, 32'hFFFFFFFF);
        id_ready = 1'b1;
        cyc();
        check("single_cnt", dec_count, 1);
        check("single_empty", id_valid, 0);

        // Back-to-back stream at full throughput.
        put(32'hFE112E23, 32'h4, 32'hFFFFFFFC, 3'd2, 1'b0);
        check("b2b_rdy0", if_ready, 1);
        cyc();
        put(32'h123450B7, 32'h8, 32'h12345000, 3'd4, 1'b0);
        check("b2b_rdy1", if_ready, 1);
        check("b2b_head_sw", id_imm, 32'hFFFFFFFC);
        cyc();
        put(32'hFF9FF06F, 32'hC, 32'hFFFFFFF8, 3'd5, 1'b0);
        check("b2b_rdy2", if_ready, 1);
        check("b2b_head_lui", id_imm, 32'h12345000);
        cyc();
        if_valid = 1'b0;
        check("b2b_head_jal", id_imm, 32'hFFFFFFF8);
        cyc();
        cyc();
        check("b2b_cnt", dec_count, exp_cnt);

        // Unknown opcode in order between legal ones, plus an R-type.
        put(32'hFFF00093, 32'h10, 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc();
        put(32'h0000007F, 32'h14, 32'h0, 3'd0, 1'b1);
        cyc();
        put(32'h002081B3, 32'h18, 32'h0, 3'd0, 1'b0);
        cyc();
        if_valid = 1'b0;
        cyc();
        cyc();

        // Stall: buffer fills, holds head, then drains in order.
        id_ready = 1'b0;
        put(32'hFFF00093, 32'h20, 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc();
        put(32'hFE112E23, 32'h24, 32'hFFFFFFFC, 3'd2, 1'b0);
        cyc();
        put(32'hFF9FF06F, 32'h28, 32'hFFFFFFF8, 3'd5, 1'b0);
        check("stall_rdy", if_ready, 0);
        check("stall_instr", id_instr, 32'hFFF00093);
        check("stall_pc", id_pc, 32'h20);
        cyc();
        cyc();
        check("stall_hold_pc", id_pc, 32'h20);
        check("stall_hold_vld", id_valid, 1);
        id_ready = 1'b1;
        cyc();
        check("drain_rdy", if_ready, 1);
        cyc();
        if_valid = 1'b0;
        cyc();
        cyc();
        check("drain_empty", id_valid, 0);

        // Flush with two entries and a same-cycle input.
        id_ready = 1'b0;
        put(32'hFFF00093, 32'h30, 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc();
        put(32'h123450B7, 32'h34, 32'h12345000, 3'd4, 1'b0);
        cyc();
        put(32'hFF9FF06F, 32'h38, 32'hFFFFFFF8, 3'd5, 1'b0);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        if_valid = 1'b0;
        check("flush_vld", id_valid, 0);
        check("flush_rdy", if_ready, 1);
        check("flush_cnt", dec_count, exp_cnt);
        id_ready = 1'b1;
        cyc();
        cyc();
        check("flush_quiet", id_valid, 0);

        // Flush with a simultaneous pop in the full state.
        id_ready = 1'b0;
        put(32'hFE112E23, 32'h40, 32'hFFFFFFFC, 3'd2, 1'b0);
        cyc();
        put(32'h123450B7, 32'h44, 32'h12345000, 3'd4, 1'b0);
        cyc();
        if_valid = 1'b0;
        id_ready = 1'b1;
        flush    = 1'b1;
        cyc();
        flush = 1'b0;
        check("flushpop_cnt", dec_count, exp_cnt);
        check("flushpop_vld", id_valid, 0);
        cyc();
        check("wrap_cnt", d2_dec_count, exp_cnt[1:0]);
        check("total_cnt", dec_count, 32'd11);

        // Asynchronous reset while full.
        id_ready = 1'b0;
        put(32'hFFF00093, 32'h50, 32'hFFFFFFFF, 3'd1, 1'b0);
        cyc();
        put(32'hFF9FF06F, 32'h54, 32'hFFFFFFF8, 3'd5, 1'b0);
        cyc();
        if_valid = 1'b0;
        check("ar_full", if_ready, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("ar_vld", id_valid, 0);
        check("ar_rdy", if_ready, 1);
        check("ar_instr", id_instr, 0);
        check("ar_imm", id_imm, 0);
        check("ar_cnt", dec_count, 0);
        check("ar_cnt2", d2_dec_count, 0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        id_ready = 1'b1;
        put(32'h123450B7, 32'h60, 32'h12345000, 3'd4, 1'b0);
        cyc();
        if_valid = 1'b0;
        check("ar_after_vld", id_valid, 1);
        check("ar_after_pc", id_pc, 32'h60);
        cyc();
        check("ar_after_cnt", dec_count, 1);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_ctrl.md
Name: decode_ctrl

Overview:
- Decode-stage controller between instruction fetch and execute in the xgriscv core.
- Accepts fetched instructions over a valid/ready handshake and computes each instruction's immediate with the existing immgen block.
- Classifies each instruction's immediate format and buffers results in a 2-entry skid buffer, so execute sees registered outputs at full throughput.
- Supports pipeline flush on branch/jump redirect and counts retired decodes.

Parameters:
- CNT_W, 32, width of the decoded-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous flush from redirect logic; drops all buffered and incoming instructions.
- if_valid  in  1  fetch presents an instruction.
- if_ready  out  1  decode can accept; registered (depends only on occupancy).
- if_instr  in  `INSTR_SIZE  fetched instruction.
- if_pc  in  `XLEN  PC of if_instr.
- id_valid  out  1  head entry valid toward execute.
- id_ready  in  1  execute accepts head entry.
- id_instr  out  `INSTR_SIZE  head instruction.
- id_pc  out  `XLEN  head PC.
- id_imm  out  `XLEN  head immediate (immgen result captured at accept).
- id_immsel  out  3  format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- id_illegal  out  1  head opcode is not one of OP_IMM/LOAD/STORE/BRANCH/LUI/AUIPC/JAL/JALR/OP.
- dec_count  out  CNT_W  number of entries handed to execute since reset.

Behaviour:
- Reset (rstn=0, asynchronous):
  - State is EMPTY and dec_count=0.
  - if_ready=1, id_valid=0.
  - id_instr, id_pc, id_imm, id_immsel and id_illegal are all 0.
- Deassertion of rstn is sampled synchronously. Asserting rstn mid-transfer discards all entries.
- Handshakes:
  - Input accept: acc = if_valid & if_ready.
  - Output transfer: pop = id_valid & id_ready.
  - Once asserted, id_valid and the id_* data stay stable until pop or flush.
- State machine, occupancy-encoded (EMPTY=0, ONE=1, TWO=2):
  - EMPTY: acc -> ONE.
  - ONE: acc & ~pop -> TWO; ~acc & pop -> EMPTY; acc & pop -> ONE (new entry becomes head); otherwise stay.
  - TWO: pop -> ONE (second entry promoted to head). acc cannot occur because if_ready=0.
  - if_ready = (state != TWO). id_valid = (state != EMPTY).
- Latency and throughput:
  - Instruction accepted in cycle N appears on id_* in cycle N+1 if the buffer was empty or popped in N.
  - Sustained throughput is 1 instruction/cycle with id_ready held high.
- Entry contents at acc:
  - if_instr and if_pc.
  - imm from the immgen instance driven by if_instr.
  - immsel and illegal derived from opcode.
  - OP (0110011) gives immsel 0, illegal 0. Unknown opcodes give imm 0, immsel 0, illegal 1.
  - Illegal entries are still passed downstream in order.
- Ordering: strict FIFO; the head is always the oldest accepted entry.
- flush:
  - Next state is EMPTY.
  - An acc in the same cycle is discarded.
  - A pop in the same cycle completes and counts.
  - if_ready=1 in the following cycle.
- dec_count increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- Simultaneous pop and flush in state TWO: head is consumed and counted, the second entry is dropped.

Decomposition:
- Opcode constants (OP_IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OP) and immsel encodings belong in xgriscv_defines.v as `defines, shared with immgen and the main decoder.
- One sub-module: immgen (existing), instantiated once on the input side.

Test Plan:
- Reset, then single accept of if_instr=0xFFF00093 (addi x1,x0,-1), pc=0x0 -> next cycle id_valid=1, id_imm=0xFFFFFFFF, id_immsel=1, id_illegal=0; pop -> dec_count=1.
- Back-to-back accepts with id_ready=1: 0xFE112E23 (sw -4), 0x123450B7 (lui), 0xFF9FF06F (jal -8).
  - id_imm sequence must be 0xFFFFFFFC/2, 0x12345000/4, 0xFFFFFFF8/5 (imm/immsel) on consecutive cycles.
  - if_ready stays 1 throughout.
- id_ready=0 while streaming -> after 2 accepts if_ready=0 and id_* hold the first entry; raise id_ready -> entries drain in order and if_ready returns 1 one cycle later.
- flush asserted with buffer TWO and if_valid=1 -> next cycle id_valid=0, if_ready=1, dec_count unchanged; the same-cycle input is never emitted.
- Unknown opcode 0x0000007F -> id_illegal=1, id_imm=0, id_immsel=0, delivered in order between two legal instructions.
- Drive rstn=0 asynchronously mid-stream in state TWO -> outputs clear immediately without a clock edge; after release the first accepted instruction appears normally.
